// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 size codes,
// FSM state encoding and the request snapshot held while an access is in flight.
package mem_stage_lsu_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WAIT_GNT = ST_WAIT_GNT,
    WAIT_RSP = ST_WAIT_RSP
  } lsu_state_e;

  typedef struct packed {
    logic                we;
    logic [2:0]          funct3;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
    logic [4:0]          rd;
    logic                to_reg;
    logic                reg_write;
  } lsu_req_t;

  // Halfwords need an even address; words (and undefined sizes) need a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = a[0];
      default:     mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response port: req/gnt handshake plus rvalid response.
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the addressed lane out of the raw read word and
// sign- or zero-extends it according to the access size.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0]        lane;
  logic signed [XLEN-1:0] sext_b;
  logic signed [XLEN-1:0] sext_h;

  always_comb begin
    lane   = rdata >> {offset, 3'b000};
    sext_b = $signed(lane[7:0]);
    sext_h = $signed(lane[15:0]);
    case (funct3)
      F3_B:    data = sext_b;
      F3_H:    data = sext_h;
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses, stalls the pipeline
// until the response arrives, and passes non-memory results straight through.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_wb_ctrl_toReg,
  input  logic              in_wb_ctrl_regWrite,
  mem_stage_lsu_if.master   dmem,
  output logic              stall,
  output logic              out_valid,
  output logic              out_wb_ctrl_toReg,
  output logic              out_wb_ctrl_regWrite,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_mem_rdata,
  output logic              misalign
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  lsu_req_t        cur;
  logic            mem_op;
  logic            mis;
  logic [XLEN-1:0] load_data;

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (req_q.funct3),
    .offset (req_q.addr[1:0]),
    .rdata  (dmem.rdata),
    .data   (load_data)
  );

  always_comb begin
    mem_op = in_valid & (in_mem_read | in_mem_write);
    mis    = is_misaligned(in_funct3, in_alu_result[1:0]);

    // Request fields come from the live inputs on the issue cycle and from the snapshot afterwards.
    cur.we        = in_mem_write;
    cur.funct3    = in_funct3;
    cur.addr      = in_alu_result;
    cur.wdata     = in_wdata;
    cur.rd        = in_rd;
    cur.to_reg    = in_wb_ctrl_toReg;
    cur.reg_write = in_wb_ctrl_regWrite;
    if (state_q != IDLE) cur = req_q;

    state_d = state_q;
    req_d   = req_q;

    dmem.req   = 1'b0;
    dmem.we    = cur.we;
    dmem.addr  = {cur.addr[ADDR_W-1:2], 2'b00};
    case (cur.funct3[1:0])
      2'b00: begin
        dmem.be    = 4'b0001 << cur.addr[1:0];
        dmem.wdata = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        dmem.be    = 4'b0011 << cur.addr[1:0];
        dmem.wdata = {2{cur.wdata[15:0]}};
      end
      default: begin
        dmem.be    = 4'b1111;
        dmem.wdata = cur.wdata;
      end
    endcase

    stall                = 1'b0;
    out_valid            = 1'b0;
    out_wb_ctrl_toReg    = 1'b0;
    out_wb_ctrl_regWrite = 1'b0;
    out_rd               = '0;
    out_alu_result       = '0;
    out_mem_rdata        = '0;
    misalign             = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && !mis) begin
          dmem.req = 1'b1;
          stall    = 1'b1;
          req_d    = cur;
          state_d  = dmem.gnt ? WAIT_RSP : WAIT_GNT;
        end else if (in_valid) begin
          out_valid            = 1'b1;
          out_wb_ctrl_toReg    = in_wb_ctrl_toReg;
          out_wb_ctrl_regWrite = in_wb_ctrl_regWrite & ~mem_op;
          out_rd               = in_rd;
          out_alu_result       = in_alu_result;
          misalign             = mem_op;
        end
      end
      WAIT_GNT: begin
        dmem.req = 1'b1;
        stall    = 1'b1;
        if (dmem.gnt) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          stall                = 1'b0;
          out_valid            = 1'b1;
          out_wb_ctrl_toReg    = req_q.to_reg;
          out_wb_ctrl_regWrite = req_q.reg_write;
          out_rd               = req_q.rd;
          out_alu_result       = req_q.addr;
          out_mem_rdata        = req_q.we ? '0 : load_data;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held every output is forced quiet, so nothing is issued from IDLE either.
    if (!reset) begin
      dmem.req             = 1'b0;
      dmem.we              = 1'b0;
      dmem.be              = '0;
      dmem.addr            = '0;
      dmem.wdata           = '0;
      stall                = 1'b0;
      out_valid            = 1'b0;
      out_wb_ctrl_toReg    = 1'b0;
      out_wb_ctrl_regWrite = 1'b0;
      out_rd               = '0;
      out_alu_result       = '0;
      out_mem_rdata        = '0;
      misalign             = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single-cycle IDLE cases plus
// hand-written load, store and reset sequences.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_wdata;
  logic [4:0]  in_rd;
  logic        in_wb_ctrl_toReg, in_wb_ctrl_regWrite;
  logic        stall, out_valid, out_wb_ctrl_toReg, out_wb_ctrl_regWrite, misalign;
  logic [4:0]  out_rd;
  logic [31:0] out_alu_result, out_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu_if dif ();

  mem_stage_lsu dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_mem_read          (in_mem_read),
    .in_mem_write         (in_mem_write),
    .in_funct3            (in_funct3),
    .in_alu_result        (in_alu_result),
    .in_wdata             (in_wdata),
    .in_rd                (in_rd),
    .in_wb_ctrl_toReg     (in_wb_ctrl_toReg),
    .in_wb_ctrl_regWrite  (in_wb_ctrl_regWrite),
    .dmem                 (dif),
    .stall                (stall),
    .out_valid            (out_valid),
    .out_wb_ctrl_toReg    (out_wb_ctrl_toReg),
    .out_wb_ctrl_regWrite (out_wb_ctrl_regWrite),
    .out_rd               (out_rd),
    .out_alu_result       (out_alu_result),
    .out_mem_rdata        (out_mem_rdata),
    .misalign             (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        vld, rd_op, wr_op;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        to_reg, reg_wr;
    logic        e_valid, e_regwr, e_mis;
  } vec_t;

  vec_t vecs[6];

  task automatic drive(input logic vld, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic to_reg, input logic reg_wr);
    in_valid = vld; in_mem_read = rd_op; in_mem_write = wr_op; in_funct3 = f3;
    in_alu_result = alu; in_wdata = wd; in_rd = rd;
    in_wb_ctrl_toReg = to_reg; in_wb_ctrl_regWrite = reg_wr;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, f3, addr, 32'h0, 5'd7, 1'b1, 1'b1);
    dif.gnt = 1'b1; dif.rvalid = 1'b0;
    @(negedge clk);
    chk({name, " req"}, {31'b0, dif.req}, 32'd1);
    chk({name, " we"}, {31'b0, dif.we}, 32'd0);
    chk({name, " addr"}, dif.addr, addr & 32'hFFFF_FFFC);
    chk({name, " stall0"}, {31'b0, stall}, 32'd1);
    chk({name, " valid0"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    dif.gnt = 1'b0; dif.rvalid = 1'b1; dif.rdata = rdata;
    @(negedge clk);
    chk({name, " stall1"}, {31'b0, stall}, 32'd0);
    chk({name, " req1"}, {31'b0, dif.req}, 32'd0);
    chk({name, " valid1"}, {31'b0, out_valid}, 32'd1);
    chk({name, " rdata"}, out_mem_rdata, exp);
    chk({name, " rd"}, {27'b0, out_rd}, 32'd7);
    chk({name, " regwr"}, {31'b0, out_wb_ctrl_regWrite}, 32'd1);
    @(posedge clk); #1;
    dif.rvalid = 1'b0;
    idle_inputs();
  endtask

  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input int gnt_delay);
    drive(1'b1, 1'b0, 1'b1, f3, addr, wd, 5'd0, 1'b0, 1'b0);
    dif.gnt = (gnt_delay == 0); dif.rvalid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        dif.gnt = (i == gnt_delay);
      end
      @(negedge clk);
      chk($sformatf("%s req c%0d", name, i), {31'b0, dif.req}, 32'd1);
      chk($sformatf("%s we c%0d", name, i), {31'b0, dif.we}, 32'd1);
      chk($sformatf("%s be c%0d", name, i), {28'b0, dif.be}, {28'b0, e_be});
      chk($sformatf("%s wdata c%0d", name, i), dif.wdata, e_wdata);
      chk($sformatf("%s addr c%0d", name, i), dif.addr, addr & 32'hFFFF_FFFC);
      chk($sformatf("%s stall c%0d", name, i), {31'b0, stall}, 32'd1);
    end
    @(posedge clk); #1;
    dif.gnt = 1'b0;
    @(negedge clk);
    chk({name, " rsp wait stall"}, {31'b0, stall}, 32'd1);
    chk({name, " rsp wait req"}, {31'b0, dif.req}, 32'd0);
    @(posedge clk); #1;
    dif.rvalid = 1'b1; dif.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk({name, " done stall"}, {31'b0, stall}, 32'd0);
    chk({name, " done valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, " done rdata"}, out_mem_rdata, 32'h0);
    @(posedge clk); #1;
    dif.rvalid = 1'b0;
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{"alu pass", 1, 0, 0, F3_W,  32'h10,  5'd5, 0, 1, 1, 1, 0};
    vecs[1] = '{"lw mis",   1, 1, 0, F3_W,  32'h102, 5'd3, 1, 1, 1, 0, 1};
    vecs[2] = '{"lh mis",   1, 1, 0, F3_H,  32'h101, 5'd4, 1, 1, 1, 0, 1};
    vecs[3] = '{"lhu mis",  1, 1, 0, F3_HU, 32'h103, 5'd6, 1, 1, 1, 0, 1};
    vecs[4] = '{"sw mis",   1, 0, 1, F3_W,  32'h203, 5'd0, 0, 0, 1, 0, 1};
    vecs[5] = '{"bubble",   0, 0, 0, F3_W,  32'h44,  5'd9, 0, 1, 0, 0, 0};

    reset = 1'b0;
    dif.gnt = 1'b0; dif.rvalid = 1'b0; dif.rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 5'd1, 1'b1, 1'b1);
    @(negedge clk);
    chk("reset req", {31'b0, dif.req}, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset valid", {31'b0, out_valid}, 32'd0);
    chk("reset rd", {27'b0, out_rd}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].rd_op, vecs[i].wr_op, vecs[i].f3, vecs[i].alu, 32'h0,
            vecs[i].rd, vecs[i].to_reg, vecs[i].reg_wr);
      @(negedge clk);
      chk({vecs[i].name, " valid"}, {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      chk({vecs[i].name, " regwr"}, {31'b0, out_wb_ctrl_regWrite}, {31'b0, vecs[i].e_regwr});
      chk({vecs[i].name, " misalign"}, {31'b0, misalign}, {31'b0, vecs[i].e_mis});
      chk({vecs[i].name, " req"}, {31'b0, dif.req}, 32'd0);
      chk({vecs[i].name, " stall"}, {31'b0, stall}, 32'd0);
      chk({vecs[i].name, " memdata"}, out_mem_rdata, 32'd0);
      if (vecs[i].e_valid) begin
        chk({vecs[i].name, " rd"}, {27'b0, out_rd}, {27'b0, vecs[i].rd});
        chk({vecs[i].name, " alu"}, out_alu_result, vecs[i].alu);
      end
      @(posedge clk); #1;
    end
    idle_inputs();

    do_load("lw",  F3_W,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb3", F3_B,  32'h103, 32'h80123456, 32'hFFFFFF80);
    do_load("lbu3", F3_BU, 32'h103, 32'h80123456, 32'h00000080);
    do_load("lhu2", F3_HU, 32'h102, 32'h80123456, 32'h00008012);
    do_load("lh2", F3_H,  32'h102, 32'h80123456, 32'hFFFF8012);
    do_load("lb1", F3_B,  32'h101, 32'h80123456, 32'h00000034);
    do_load("lh0", F3_H,  32'h200, 32'h1234F00D, 32'hFFFFF00D);

    do_store("sb", F3_B, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB, 3);
    do_store("sh", F3_H, 32'h102, 32'h1234CAFE, 4'b1100, 32'hCAFECAFE, 0);
    do_store("sw", F3_W, 32'h104, 32'h11223344, 4'b1111, 32'h11223344, 1);

    // Reset while waiting for grant: the request must drop at once.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h300, 32'h0, 5'd2, 1'b1, 1'b1);
    dif.gnt = 1'b0;
    @(negedge clk);
    chk("rst gnt pre req", {31'b0, dif.req}, 32'd1);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst gnt req", {31'b0, dif.req}, 32'd0);
    chk("rst gnt stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset while waiting for the response; a late rvalid must be ignored.
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 5'd2, 1'b1, 1'b1);
    dif.gnt = 1'b1;
    @(posedge clk); #1;
    dif.gnt = 1'b0;
    @(negedge clk);
    chk("rst rsp pre stall", {31'b0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst rsp stall", {31'b0, stall}, 32'd0);
    chk("rst rsp req", {31'b0, dif.req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dif.rvalid = 1'b1; dif.rdata = 32'h12345678;
    @(negedge clk);
    chk("late rvalid valid", {31'b0, out_valid}, 32'd0);
    chk("late rvalid stall", {31'b0, stall}, 32'd0);
    chk("late rvalid data", out_mem_rdata, 32'd0);
    @(posedge clk); #1;
    dif.rvalid = 1'b0;

    do_load("post rst lw", F3_W, 32'h500, 32'hCAFEF00D, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
